cpu_nic_responder: RTL and testbench

- Network interface controller: the responder side of the CPU's NIC port (nicEn, nicWrEn, addr_nic, d_in_nic, d_out_nic).
- Bridges the CPU to one mesh router local port.
- Holds an output (CPU→network) buffer and an input (network→CPU) buffer.
- Exposes a 2-bit register map to the CPU and a send/ready handshake with polarity-gated injection to the router.

---
 rtl/nic_pkg.sv | 14 +
 rtl/nic_fifo.sv | 70 +++++++
 rtl/cpu_nic_responder.sv | 149 ++++++++++++++
 tb/tb_cpu_nic_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// nic_pkg: shared constants for the CPU-side NIC responder.
// CPU register map addresses, the default packet width and the position
// of the virtual-channel bit inside a packet (bit 0 is the MSB).
package nic_pkg;

  localparam int NIC_DATA_WIDTH = 64;
  localparam int NIC_VC_BIT     = 0;

  localparam logic [1:0] NIC_ADDR_IN_DATA    = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_DATA   = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STATUS = 2'b11;

endpackage

// File: rtl/nic_fifo.sv
// nic_fifo: small circular packet buffer used once per NIC direction.
// The head entry is visible combinationally so the router side can see the
// packet it is about to take. A push into a full buffer is accepted only
// when a pop happens on the same edge and frees the slot.
module nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  logic [0:DATA_WIDTH-1]                din,
  input  logic                                 pop,
  output logic [0:DATA_WIDTH-1]                head,
  output logic                                 full,
  output logic                                 empty,
  output logic [$clog2(BUF_DEPTH):0]           count
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [0:DATA_WIDTH-1] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  // Wrap explicitly at BUF_DEPTH-1 so a depth of 1 also behaves.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(BUF_DEPTH));
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Packet storage; contents need no reset because empty gates every use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= inc_ptr(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= inc_ptr(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_nic_responder.sv
// cpu_nic_responder: CPU-facing NIC bridging the CPU register port to one
// mesh router local port. One buffer carries CPU packets to the network,
// the other carries network packets to the CPU.
// Optional build macro NIC_PKT_COUNT_EN adds saturating sent/received
// packet counters readable in the upper 32 bits of the status registers.
module cpu_nic_responder
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = NIC_DATA_WIDTH,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic [0:1]            addr_nic,
  input  logic [0:DATA_WIDTH-1] d_in_nic,
  output logic [0:DATA_WIDTH-1] d_out_nic,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic                  cpu_rd;
  logic                  in_push;
  logic                  in_pop;
  logic [0:DATA_WIDTH-1] in_head;
  logic                  in_full;
  logic                  in_empty;
  logic [CNT_W-1:0]      in_count;
  logic                  out_push;
  logic [0:DATA_WIDTH-1] out_head;
  logic                  out_full;
  logic                  out_empty;
  logic [CNT_W-1:0]      out_count;
  logic [0:DATA_WIDTH-1] rd_data_next;
  logic [0:DATA_WIDTH-1] d_out_nic_reg;
  logic                  unused_counts;

  assign cpu_rd   = nicEn && !nicWrEn;
  assign in_pop   = cpu_rd && (addr_nic == NIC_ADDR_IN_DATA);
  assign out_push = nicEn && nicWrEn && (addr_nic == NIC_ADDR_OUT_DATA);

  // A full input buffer deasserts net_ri, so a CPU pop on that edge never
  // coincides with an accepted network push.
  assign net_ri  = !in_full;
  assign in_push = net_si && net_ri;

  // Inject only when the head packet's VC bit matches the router phase.
  assign net_so = !out_empty && net_ro && (out_head[NIC_VC_BIT] == net_polarity);
  assign net_do = out_empty ? '0 : out_head;

  assign unused_counts = ^{in_count, out_count};

  nic_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .din   (net_di),
    .pop   (in_pop),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  nic_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .din   (d_in_nic),
    .pop   (net_so),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

`ifdef NIC_PKT_COUNT_EN
  logic [31:0] tx_cnt_reg;
  logic [31:0] rx_cnt_reg;

  // Saturating packet counters for completed network transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
    end else begin
      if (net_so && (tx_cnt_reg != 32'hFFFF_FFFF)) begin
        tx_cnt_reg <= tx_cnt_reg + 32'd1;
      end
      if (in_push && (rx_cnt_reg != 32'hFFFF_FFFF)) begin
        rx_cnt_reg <= rx_cnt_reg + 32'd1;
      end
    end
  end
`endif

  // Read-data select for the register map; status flags live in the LSB.
  always_comb begin
    rd_data_next = '0;
    case (addr_nic)
      NIC_ADDR_IN_DATA: begin
        if (!in_empty) begin
          rd_data_next = in_head;
        end
      end
      NIC_ADDR_IN_STATUS: begin
`ifdef NIC_PKT_COUNT_EN
        rd_data_next[0:31] = rx_cnt_reg;
`endif
        rd_data_next[DATA_WIDTH-1] = !in_empty;
      end
      NIC_ADDR_OUT_STATUS: begin
`ifdef NIC_PKT_COUNT_EN
        rd_data_next[0:31] = tx_cnt_reg;
`endif
        rd_data_next[DATA_WIDTH-1] = out_full;
      end
      default: begin
        rd_data_next = '0;
      end
    endcase
  end

  // Registered CPU read data, held between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out_nic_reg <= '0;
    end else if (cpu_rd) begin
      d_out_nic_reg <= rd_data_next;
    end
  end

  assign d_out_nic = d_out_nic_reg;

endmodule

// File: tb/tb_cpu_nic_responder.sv
// tb_cpu_nic_responder: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the two packet buffers.
module tb_cpu_nic_responder;
  import nic_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 2;

  logic          clk;
  logic          reset;
  logic          nicEn;
  logic          nicWrEn;
  logic [0:1]    addr_nic;
  logic [0:DW-1] d_in_nic;
  logic [0:DW-1] d_out_nic;
  logic          net_si;
  logic          net_ri;
  logic [0:DW-1] net_di;
  logic          net_so;
  logic          net_ro;
  logic [0:DW-1] net_do;
  logic          net_polarity;

  cpu_nic_responder #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .addr_nic     (addr_nic),
    .d_in_nic     (d_in_nic),
    .d_out_nic    (d_out_nic),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [0:DW-1] in_q[$];
  logic [0:DW-1] out_q[$];
  logic [0:DW-1] exp_dout;
  int unsigned   tx_cnt;
  int unsigned   rx_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    in_q.delete();
    out_q.delete();
    exp_dout = '0;
    tx_cnt   = 0;
    rx_cnt   = 0;
  endtask

  // One clock cycle: drive inputs (called just after a falling edge), check
  // combinational outputs, advance the model, check read data after the edge.
  task automatic step(input logic en, input logic wr, input logic [1:0] addr,
                      input logic [0:DW-1] din, input logic si,
                      input logic [0:DW-1] di, input logic ro, input logic pol);
    logic [0:DW-1] hd;
    logic [0:DW-1] st;
    logic          exp_ri;
    logic          exp_so;
    int            in_sz;
    int            out_sz;
    nicEn = en; nicWrEn = wr; addr_nic = addr; d_in_nic = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    #1;
    in_sz  = in_q.size();
    out_sz = out_q.size();
    hd     = (out_sz != 0) ? out_q[0] : '0;
    exp_ri = (in_sz < DEPTH);
    exp_so = (out_sz != 0) && ro && (hd[0] == pol);
    chk("net_ri", {63'd0, net_ri}, {63'd0, exp_ri});
    chk("net_so", {63'd0, net_so}, {63'd0, exp_so});
    chk("net_do", net_do, hd);

    if (en && !wr) begin
      st = '0;
      case (addr)
        NIC_ADDR_IN_DATA:    exp_dout = (in_sz != 0) ? in_q[0] : '0;
        NIC_ADDR_IN_STATUS: begin
`ifdef NIC_PKT_COUNT_EN
          st[0:31] = rx_cnt;
`endif
          st[DW-1] = (in_sz != 0);
          exp_dout = st;
        end
        NIC_ADDR_OUT_STATUS: begin
`ifdef NIC_PKT_COUNT_EN
          st[0:31] = tx_cnt;
`endif
          st[DW-1] = (out_sz == DEPTH);
          exp_dout = st;
        end
        default: exp_dout = '0;
      endcase
    end
    if (en && !wr && addr == NIC_ADDR_IN_DATA && in_sz != 0) void'(in_q.pop_front());
    if (si && exp_ri) begin
      in_q.push_back(di);
      if (rx_cnt != 32'hFFFF_FFFF) rx_cnt++;
    end
    if (exp_so) begin
      void'(out_q.pop_front());
      if (tx_cnt != 32'hFFFF_FFFF) tx_cnt++;
    end
    if (en && wr && addr == NIC_ADDR_OUT_DATA && (out_sz < DEPTH || exp_so)) out_q.push_back(din);

    @(posedge clk);
    #1;
    chk("d_out_nic", d_out_nic, exp_dout);
    if (en) $display("txn t=%0t %s addr=%b wdata=%h rdata=%h", $time, wr ? "wr" : "rd", addr, din, d_out_nic);
    @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [0:DW-1] d, input logic ro, input logic pol);
    step(1'b1, 1'b1, a, d, 1'b0, '0, ro, pol);
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic ro, input logic pol);
    step(1'b1, 1'b0, a, '0, 1'b0, '0, ro, pol);
  endtask

  task automatic net_push(input logic [0:DW-1] d);
    step(1'b0, 1'b0, 2'b00, '0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ro, input logic pol);
    step(1'b0, 1'b0, 2'b00, '0, 1'b0, '0, ro, pol);
  endtask

  // Assert reset between edges; outputs must clear without waiting for clk.
  task automatic mid_reset();
    nicEn = 0; nicWrEn = 0; net_si = 0; net_ro = 1; net_polarity = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_net_so", {63'd0, net_so}, 64'd0);
    chk("rst_net_do", net_do, 64'd0);
    chk("rst_d_out", d_out_nic, 64'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    nicEn = 0; nicWrEn = 0; addr_nic = 2'b00; d_in_nic = '0;
    net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("init_d_out", d_out_nic, 64'd0);
    chk("init_net_so", {63'd0, net_so}, 64'd0);
    chk("init_net_do", net_do, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("init_net_ri", {63'd0, net_ri}, 64'd1);

    // Immediate send with VC bit 0, then a VC-bit-1 packet held until polarity 1.
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h0000_0000_0000_00AA, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h8000_0000_0000_00BB, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // Overfill the output buffer with the router stalled.
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h0000_0000_0000_0002, 1'b0, 1'b0);
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h0000_0000_0000_0003, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_OUT_STATUS, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    cpu_rd(NIC_ADDR_OUT_STATUS, 1'b0, 1'b0);

    // Router fills the input buffer; CPU drains it and over-reads.
    net_push(64'h0000_0000_0000_1234);
    net_push(64'h0000_0000_0000_5678);
    net_push(64'h0000_0000_0000_9999);
    cpu_rd(NIC_ADDR_IN_STATUS, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_IN_DATA, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_IN_DATA, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_IN_DATA, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_OUT_DATA, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_IN_STATUS, 1'b0, 1'b0);

    // Pop and push on the same edge with a full input buffer.
    net_push(64'h0000_0000_0000_00C1);
    net_push(64'h0000_0000_0000_00C2);
    step(1'b1, 1'b0, NIC_ADDR_IN_DATA, '0, 1'b1, 64'h0000_0000_0000_00C3, 1'b0, 1'b0);
    net_push(64'h0000_0000_0000_00C4);
    cpu_rd(NIC_ADDR_IN_STATUS, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_IN_DATA, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_IN_DATA, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_OUT_STATUS, 1'b0, 1'b0);

    // Reset while the output buffer holds two packets.
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h0000_0000_0000_0011, 1'b0, 1'b0);
    cpu_wr(NIC_ADDR_OUT_DATA, 64'h0000_0000_0000_0022, 1'b0, 1'b0);
    mid_reset();
    cpu_rd(NIC_ADDR_OUT_STATUS, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [0:DW-1] rd_w;
      logic [0:DW-1] rd_n;
      rd_w = {$urandom, $urandom};
      rd_n = {$urandom, $urandom};
      step($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)), rd_w,
           $urandom_range(0, 1), rd_n, ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
    end
    cpu_rd(NIC_ADDR_IN_STATUS, 1'b0, 1'b0);
    cpu_rd(NIC_ADDR_OUT_STATUS, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
